// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver: per-digit raw/hex storage, slot scan with blanking gap,
// leading-zero blanking and frame tick. Define SEG7_PWM_EN to add the brightness port and PWM gating.
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 2,
  parameter int REFRESH_DIV  = 25000,
  parameter int BLANK_CYCLES = 16,
  parameter int PWM_BITS     = 4,
  localparam int AW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int SW = $clog2(REFRESH_DIV)
) (
  input  logic                  clkin_50,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [7:0]            wr_data,
  input  logic                  wr_hex,
  input  logic                  lz_blank,
`ifdef SEG7_PWM_EN
  input  logic [PWM_BITS-1:0]   brightness,
`endif
  output logic [7:0]            seg7_data,
  output logic [NUM_DIGITS-1:0] seg7_char,
  output logic                  frame_tick
);

  localparam logic [SW-1:0] LAST_SLOT = SW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] BLANK_L   = SW'(BLANK_CYCLES);
  localparam logic [DW-1:0] LAST_DIG  = DW'(NUM_DIGITS - 1);

  function automatic logic [6:0] hex_font(input logic [3:0] n);
    case (n)
      4'h0: hex_font = 7'h3F;  4'h1: hex_font = 7'h06;
      4'h2: hex_font = 7'h5B;  4'h3: hex_font = 7'h4F;
      4'h4: hex_font = 7'h66;  4'h5: hex_font = 7'h6D;
      4'h6: hex_font = 7'h7D;  4'h7: hex_font = 7'h07;
      4'h8: hex_font = 7'h7F;  4'h9: hex_font = 7'h6F;
      4'hA: hex_font = 7'h77;  4'hB: hex_font = 7'h7C;
      4'hC: hex_font = 7'h39;  4'hD: hex_font = 7'h5E;
      4'hE: hex_font = 7'h79;  default: hex_font = 7'h71;
    endcase
  endfunction

  logic [7:0]            val_q [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] hex_q;
  logic [SW-1:0]         slot_q, slot_d;
  logic [DW-1:0]         dig_q, dig_d;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] char_q, char_d;
  logic                  tick_q, tick_d;

  logic                  wrap_slot, in_gap, lz_run, pwm_on;
  logic [NUM_DIGITS-1:0] blank;
  logic [7:0]            dec_all [NUM_DIGITS];
  logic [7:0]            seg_sel;

`ifdef SEG7_PWM_EN
  logic [PWM_BITS-1:0]   pwm_q;
  // All-ones brightness means fully on rather than (2^N-1)/2^N duty.
  assign pwm_on = (brightness == '1) || (pwm_q < brightness);
`else
  assign pwm_on = 1'b1;
`endif

  always_comb begin
    wrap_slot = (slot_q == LAST_SLOT);
    slot_d    = wrap_slot ? '0 : slot_q + 1'b1;
    dig_d     = dig_q;
    if (wrap_slot) dig_d = (dig_q == LAST_DIG) ? '0 : dig_q + 1'b1;
    tick_d    = wrap_slot && (dig_q == LAST_DIG);
    in_gap    = (slot_q < BLANK_L);
  end

  // Leading-zero chain runs from the most significant digit down; any non-blank digit breaks it.
  always_comb begin
    lz_run = 1'b1;
    blank  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lz_run   = lz_run & hex_q[i] & (val_q[i][3:0] == 4'h0) & ~val_q[i][7];
      blank[i] = lz_blank & lz_run & (i != 0);
    end
  end

  always_comb begin
    seg_sel = 8'h00;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (blank[i])      dec_all[i] = 8'h00;
      else if (hex_q[i]) dec_all[i] = {val_q[i][7], hex_font(val_q[i][3:0])};
      else               dec_all[i] = val_q[i];
      if (dig_q == DW'(i)) seg_sel = dec_all[i];
    end
  end

  always_comb begin
    seg_d  = in_gap ? 8'h00 : seg_sel;
    char_d = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      char_d[i] = !in_gap && pwm_on && (dig_q == DW'(i));
  end

  always_ff @(posedge clkin_50) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) val_q[i] <= 8'h00;
      hex_q  <= '0;
      slot_q <= '0;
      dig_q  <= '0;
      seg_q  <= 8'h00;
      char_q <= '0;
      tick_q <= 1'b0;
`ifdef SEG7_PWM_EN
      pwm_q  <= '0;
`endif
    end else begin
      slot_q <= slot_d;
      dig_q  <= dig_d;
      seg_q  <= seg_d;
      char_q <= char_d;
      tick_q <= tick_d;
`ifdef SEG7_PWM_EN
      pwm_q  <= pwm_q + 1'b1;
`endif
      // Addresses at or above NUM_DIGITS match no entry and are dropped.
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (wr_en && (wr_addr == AW'(i))) begin
          val_q[i] <= wr_data;
          hex_q[i] <= wr_hex;
        end
      end
    end
  end

  assign seg7_data  = seg_q;
  assign seg7_char  = char_q;
  assign frame_tick = tick_q;

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised, time-multiplexed seven-segment display driver for the LogicalStep board family, generalising the fixed two-digit segment drive to NUM_DIGITS digits. A host writes per-digit raw-segment or hex-coded values; the block scans the digits with an inter-digit blanking gap, hex-decodes with optional leading-zero blanking, and emits a frame tick per full scan. It sits between the Qsys PIO/bridge logic and the `seg7_data` / `seg7_char*` pins.

## Interface
- `NUM_DIGITS`, 2: number of digits scanned, legal 1..8.
- `REFRESH_DIV`, 25000: clock cycles per digit slot, ≥ 2.
- `BLANK_CYCLES`, 16: cycles at start of each slot with all digits off; must be < `REFRESH_DIV`.
- `PWM_BITS`, 4: brightness resolution (only with `SEG7_PWM_EN`).
- `clkin_50`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  write strobe, one cycle per write.
- `wr_addr`  in  max(1,$clog2(NUM_DIGITS))  digit index; 0 = rightmost/least significant.
- `wr_data`  in  8  raw mode: segments {dp,g,f,e,d,c,b,a}; hex mode: bit7 = dp, bits3:0 = nibble.
- `wr_hex`  in  1  0 = raw, 1 = hex mode for this digit.
- `lz_blank`  in  1  enable leading-zero blanking.
- `brightness`  in  PWM_BITS  duty level (only with `SEG7_PWM_EN`).
- `seg7_data`  out  8  active-high segments of active digit.
- `seg7_char`  out  NUM_DIGITS  one-hot active-high digit select.
- `frame_tick`  out  1  one-cycle pulse at end of each full scan.

## Operation
- Storage: per digit, 8-bit value + 1 mode bit. Write with `wr_addr` ≥ `NUM_DIGITS` ignored. Write lands at the sampling edge.
- Slot counter `slot_cnt` 0..REFRESH_DIV-1; at REFRESH_DIV-1 it wraps to 0 and digit index `dig` advances; `dig` wraps NUM_DIGITS-1 → 0.
- `frame_tick` asserted in the cycle following the edge where `dig` wraps to 0.
- Decode: raw → stored byte; hex → font(nibble) | dp<<7. Font (g..a): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- Leading-zero blanking (`lz_blank`=1): digit i>0 blanked (seg7_data=00) if it and every digit above it are hex mode, nibble 0, dp 0. Digit 0 never blanked. Raw-mode digit stops the chain.
- Drive: during `slot_cnt` < BLANK_CYCLES, `seg7_char`=0 and `seg7_data`=00; otherwise `seg7_char`=1<<dig, `seg7_data`=decoded value of `dig`.
- Reset: all storage 0 (raw, 00), `slot_cnt`=0, `dig`=0, PWM counter 0; outputs `seg7_data`=00, `seg7_char`=0, `frame_tick`=0. Reset mid-scan restarts at digit 0, slot cycle 0, with blanking gap.

## Timing
- All outputs registered: outputs reflect counter/storage state one cycle after it is reached.
- Write to currently displayed digit visible on `seg7_data` 2 cycles after `wr_en` edge (store, then output register).
- Full frame = NUM_DIGITS × REFRESH_DIV cycles; `frame_tick` period identical.
- Simultaneous write and slot advance: the advance uses new `dig`; the write is independent, no stall, never lost.
- NUM_DIGITS=1: `dig` constant 0, `frame_tick` every REFRESH_DIV cycles.

## Configuration
- `SEG7_PWM_EN` defined: `brightness` port present; free-running PWM_BITS counter `pwm_cnt`; digit enabled only when `pwm_cnt` < `brightness`, except all-ones forces always-on; 0 = dark (`seg7_char`=0 outside gap too). Gating is registered with other outputs.
- Undefined: no `brightness` port, no PWM counter; digit on for entire non-gap slot.

## Test plan
- NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2; reset, no writes -> `seg7_char` 0000 for 2 cycles then 0001 for 6, then 0010…; `frame_tick` once per 32 cycles; `seg7_data`=00 throughout.
- Hex writes 3,0,0,0 to digits 0..3, `lz_blank`=1 -> digit0 shows 4F, digits1..3 show 00; `lz_blank`=0 -> digits1..3 show 3F.
- Raw write 0x80 to digit2 with digit3 hex 0 -> digit3 blanked, digit2 shows 80, digit1 hex 0 shows 3F.
- Write `wr_addr`=5 (NUM_DIGITS=4) -> no storage change; write digit currently displayed -> new value on `seg7_data` exactly 2 cycles later.
- Assert `rst` mid-slot of digit 2 -> next cycle outputs 0; scan restarts digit 0 with 2-cycle gap; storage cleared.
- `SEG7_PWM_EN`, PWM_BITS=4, brightness=4 -> within active window digit on 4 of every 16 cycles; brightness=F -> always on; 0 -> never on.
